// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: core phase codes, writeback source codes,
// register-file geometry and the even-parity helper used when the
// REGFILE_PARITY_EN build option is enabled.
package gpu_pkg;

    // Core phase encodings seen by the register file
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    // Writeback source selector encodings
    typedef enum logic [1:0] {
        MUX_ALU      = 2'b00,
        MUX_MEMORY   = 2'b01,
        MUX_CONSTANT = 2'b10,
        MUX_RESERVED = 2'b11
    } reg_input_mux_e;

    // Register-file geometry
    localparam int NUM_REGS    = 16;
    localparam int NUM_GP_REGS = 13;

    // Read-only special register indices
    localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
    localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
    localparam logic [3:0] REG_THREAD_IDX = 4'd15;

    // Even-parity bit of a value; narrower data is zero-extended by the caller,
    // which leaves the parity unchanged.
    function automatic logic calc_parity(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/regfile_wb_select.sv
// Writeback source selector for the thread register file. Purely
// combinational: picks ALU, load or immediate data and reports whether the
// selection code is one that is allowed to write at all.
module regfile_wb_select
    import gpu_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic [1:0]           reg_input_mux,
    input  logic [DATA_BITS-1:0] immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid
);

    // Select the writeback value; the reserved code yields no valid data
    always_comb begin
        data  = {DATA_BITS{1'b0}};
        valid = 1'b0;
        case (reg_input_mux)
            MUX_ALU: begin
                data  = alu_out;
                valid = 1'b1;
            end
            MUX_MEMORY: begin
                data  = lsu_out;
                valid = 1'b1;
            end
            MUX_CONSTANT: begin
                data  = immediate;
                valid = 1'b1;
            end
            default: begin
                data  = {DATA_BITS{1'b0}};
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/thread_regfile.sv
// Per-thread register file of a small SIMT GPU core.
// R0-R12 are general purpose; R13 mirrors block_id, R14 holds the block
// dimension and R15 the thread index (both fixed at reset). Operands are
// read in the REQUEST phase into registered rs/rt; writeback happens in the
// UPDATE phase. Build option: define REGFILE_PARITY_EN to store an
// even-parity bit per register and flag corruption on operand reads.
module thread_regfile
    import gpu_pkg::*;
#(
    parameter int THREAD_ID         = 0,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt,
    output logic                 parity_error
);

    localparam logic [DATA_BITS-1:0] BLOCK_DIM_C  = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_IDX_C = DATA_BITS'(THREAD_ID);

    logic [DATA_BITS-1:0] regs_r [NUM_REGS];
    logic [DATA_BITS-1:0] rs_r;
    logic [DATA_BITS-1:0] rt_r;
    logic [DATA_BITS-1:0] wb_data_s;
    logic                 wb_valid_s;
    logic                 is_request_s;
    logic                 is_update_s;
    logic                 write_ok_s;

    regfile_wb_select #(
        .DATA_BITS (DATA_BITS)
    ) u_wb_select (
        .reg_input_mux (decoded_reg_input_mux),
        .immediate     (decoded_immediate),
        .alu_out       (alu_out),
        .lsu_out       (lsu_out),
        .data          (wb_data_s),
        .valid         (wb_valid_s)
    );

    assign is_request_s = (core_state == CORE_REQUEST);
    assign is_update_s  = (core_state == CORE_UPDATE);
    // Only general-purpose destinations accept writes; special registers drop them silently
    assign write_ok_s   = is_update_s && decoded_reg_write_enable &&
                          (decoded_rd_address < REG_BLOCK_IDX) && wb_valid_s;

    // Register storage, R13 block mirror and registered operand reads
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_GP_REGS; i++) begin
                regs_r[i] <= {DATA_BITS{1'b0}};
            end
            regs_r[REG_BLOCK_IDX]  <= {DATA_BITS{1'b0}};
            regs_r[REG_BLOCK_DIM]  <= BLOCK_DIM_C;
            regs_r[REG_THREAD_IDX] <= THREAD_IDX_C;
            rs_r <= {DATA_BITS{1'b0}};
            rt_r <= {DATA_BITS{1'b0}};
        end else if (enable) begin
            regs_r[REG_BLOCK_IDX] <= block_id;
            if (write_ok_s) begin
                regs_r[decoded_rd_address] <= wb_data_s;
            end
            // Reads see the pre-edge contents; REQUEST and UPDATE never overlap
            if (is_request_s) begin
                rs_r <= regs_r[decoded_rs_address];
                rt_r <= regs_r[decoded_rt_address];
            end
        end
    end

    assign rs = rs_r;
    assign rt = rt_r;

`ifdef REGFILE_PARITY_EN
    logic [NUM_REGS-1:0] par_r;
    logic                par_err_r;
    logic                rs_bad_s;
    logic                rt_bad_s;

    assign rs_bad_s = calc_parity(64'(regs_r[decoded_rs_address])) != par_r[decoded_rs_address];
    assign rt_bad_s = calc_parity(64'(regs_r[decoded_rt_address])) != par_r[decoded_rt_address];

    // Parity shadow of every register write and sticky corruption flag
    always_ff @(posedge clk) begin
        if (reset) begin
            par_r                 <= {NUM_REGS{1'b0}};
            par_r[REG_BLOCK_DIM]  <= calc_parity(64'(BLOCK_DIM_C));
            par_r[REG_THREAD_IDX] <= calc_parity(64'(THREAD_IDX_C));
            par_err_r             <= 1'b0;
        end else if (enable) begin
            par_r[REG_BLOCK_IDX] <= calc_parity(64'(block_id));
            if (write_ok_s) begin
                par_r[decoded_rd_address] <= calc_parity(64'(wb_data_s));
            end
            if (is_request_s && (rs_bad_s || rt_bad_s)) begin
                par_err_r <= 1'b1;
            end
        end
    end

    assign parity_error = par_err_r;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_thread_regfile.sv
// Self-checking bench for thread_regfile (THREAD_ID=2, THREADS_PER_BLOCK=4,
// DATA_BITS=8): a directed vector table, a randomized run against a
// behavioural model, and a parity-corruption sequence when REGFILE_PARITY_EN
// is defined.
module tb_thread_regfile;

    localparam int TID = 2;
    localparam int TPB = 4;

    localparam logic [2:0] ST_R = 3'b011;
    localparam logic [2:0] ST_U = 3'b110;
    localparam logic [2:0] ST_I = 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] rd_a;
    logic [3:0] rs_a;
    logic [3:0] rt_a;
    logic       we;
    logic [1:0] mux;
    logic [7:0] imm;
    logic [7:0] alu;
    logic [7:0] lsu;
    logic [7:0] rs;
    logic [7:0] rt;
    logic       perr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] st;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       we;
        logic [1:0] mux;
        logic [7:0] imm;
        logic [7:0] alu;
        logic [7:0] lsu;
        logic [7:0] blk;
        logic [7:0] exp_rs;
        logic [7:0] exp_rt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    logic [7:0] m_regs [16];
    logic [7:0] m_rs;
    logic [7:0] m_rt;

    thread_regfile #(
        .THREAD_ID         (TID),
        .THREADS_PER_BLOCK (TPB),
        .DATA_BITS         (8)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .block_id                 (block_id),
        .core_state               (core_state),
        .decoded_rd_address       (rd_a),
        .decoded_rs_address       (rs_a),
        .decoded_rt_address       (rt_a),
        .decoded_reg_write_enable (we),
        .decoded_reg_input_mux    (mux),
        .decoded_immediate        (imm),
        .alu_out                  (alu),
        .lsu_out                  (lsu),
        .rs                       (rs),
        .rt                       (rt),
        .parity_error             (perr)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] s,
                                input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                                input logic w, input logic [1:0] m, input logic [7:0] i,
                                input logic [7:0] al, input logic [7:0] ls, input logic [7:0] bk,
                                input logic [7:0] ers, input logic [7:0] ert);
        vec_t v;
        v.rst = r; v.en = e; v.st = s; v.rd = d; v.ra = a; v.rb = b; v.we = w;
        v.mux = m; v.imm = i; v.alu = al; v.lsu = ls; v.blk = bk;
        v.exp_rs = ers; v.exp_rt = ert;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; enable = v.en; core_state = v.st; rd_a = v.rd; rs_a = v.ra;
        rt_a = v.rb; we = v.we; mux = v.mux; imm = v.imm; alu = v.alu; lsu = v.lsu;
        block_id = v.blk;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_regs[14] = 8'(TPB);
        m_regs[15] = 8'(TID);
        m_rs = 8'h00;
        m_rt = 8'h00;
    endfunction

    // Apply the rules to the current inputs; called before the clock edge
    function automatic void model_step();
        logic [7:0] nxt [16];
        if (reset) begin
            model_reset();
        end else if (enable) begin
            nxt = m_regs;
            nxt[13] = block_id;
            if (core_state == ST_U && we && rd_a < 4'd13 && mux != 2'b11)
                nxt[rd_a] = (mux == 2'b00) ? alu : (mux == 2'b01) ? lsu : imm;
            if (core_state == ST_R) begin
                m_rs = m_regs[rs_a];
                m_rt = m_regs[rt_a];
            end
            m_regs = nxt;
        end
    endfunction

    initial begin
        drive(mk(1'b1, 1'b0, ST_I, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));

        //          rst   en    st    rd     ra     rb     we    mux    imm    alu    lsu    blk    rs     rt
        vecs.push_back(mk(1'b1, 1'b1, ST_I, 4'd0,  4'd0,  4'd0,  1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, ST_R, 4'd0,  4'd15, 4'd14, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h04));
        vecs.push_back(mk(1'b0, 1'b1, ST_U, 4'd5,  4'd0,  4'd0,  1'b1, 2'b00, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h02, 8'h04));
        vecs.push_back(mk(1'b0, 1'b1, ST_R, 4'd0,  4'd5,  4'd13, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, ST_U, 4'd5,  4'd0,  4'd0,  1'b1, 2'b10, 8'h07, 8'h99, 8'h88, 8'h00, 8'h2A, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, ST_R, 4'd0,  4'd5,  4'd5,  1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h07));
        vecs.push_back(mk(1'b0, 1'b1, ST_U, 4'd15, 4'd0,  4'd0,  1'b1, 2'b01, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h07, 8'h07));
        vecs.push_back(mk(1'b0, 1'b1, ST_U, 4'd3,  4'd0,  4'd0,  1'b1, 2'b11, 8'hBB, 8'hAA, 8'hCC, 8'h00, 8'h07, 8'h07));
        vecs.push_back(mk(1'b0, 1'b1, ST_R, 4'd0,  4'd15, 4'd3,  1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, ST_U, 4'd1,  4'd0,  4'd0,  1'b1, 2'b00, 8'h00, 8'h11, 8'h00, 8'h03, 8'h02, 8'h00));
        vecs.push_back(mk(1'b0, 1'b0, ST_U, 4'd1,  4'd0,  4'd0,  1'b1, 2'b00, 8'h00, 8'h77, 8'h00, 8'h09, 8'h02, 8'h00));
        vecs.push_back(mk(1'b0, 1'b0, ST_R, 4'd0,  4'd1,  4'd13, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h02, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, ST_R, 4'd0,  4'd1,  4'd13, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h11, 8'h03));
        vecs.push_back(mk(1'b0, 1'b1, ST_R, 4'd0,  4'd13, 4'd1,  1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h09, 8'h11));
        vecs.push_back(mk(1'b1, 1'b1, ST_U, 4'd4,  4'd0,  4'd0,  1'b1, 2'b00, 8'h00, 8'h55, 8'h00, 8'h09, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, ST_R, 4'd0,  4'd4,  4'd15, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h02));
        vecs.push_back(mk(1'b0, 1'b1, ST_U, 4'd13, 4'd0,  4'd0,  1'b1, 2'b00, 8'h00, 8'hEE, 8'h00, 8'h05, 8'h00, 8'h02));
        vecs.push_back(mk(1'b0, 1'b1, ST_R, 4'd0,  4'd13, 4'd14, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h05, 8'h04));
        vecs.push_back(mk(1'b0, 1'b1, ST_I, 4'd2,  4'd13, 4'd0,  1'b1, 2'b00, 8'h00, 8'hC3, 8'h00, 8'h06, 8'h05, 8'h04));
        vecs.push_back(mk(1'b0, 1'b1, ST_R, 4'd0,  4'd13, 4'd2,  1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h06, 8'h00));

        // Directed vectors, one clock each
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("vec%0d_rs", i), rs, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), rt, vecs[i].exp_rt);
            check($sformatf("vec%0d_perr", i), {7'd0, perr}, 8'h00);
        end

        // Randomized run against the model, starting from reset
        model_reset();
        for (int n = 0; n < 800; n++) begin
            int sel;
            reset  = (n == 0) || ($urandom_range(0, 59) == 0);
            enable = ($urandom_range(0, 7) != 0);
            sel    = $urandom_range(0, 3);
            core_state = (sel == 1) ? ST_U : (sel == 2) ? 3'($urandom_range(0, 7)) : ST_R;
            rd_a = 4'($urandom_range(0, 15));
            rs_a = 4'($urandom_range(0, 15));
            rt_a = 4'($urandom_range(0, 15));
            we   = ($urandom_range(0, 3) != 0);
            mux  = 2'($urandom_range(0, 3));
            imm  = 8'($urandom);
            alu  = 8'($urandom);
            lsu  = 8'($urandom);
            block_id = 8'($urandom);
            model_step();
            step();
            check($sformatf("rand%0d_rs", n), rs, m_rs);
            check($sformatf("rand%0d_rt", n), rt, m_rt);
            check($sformatf("rand%0d_perr", n), {7'd0, perr}, 8'h00);
        end

`ifdef REGFILE_PARITY_EN
        // Corrupt a stored bit and confirm the sticky flag
        drive(mk(1'b1, 1'b1, ST_I, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        step();
        drive(mk(1'b0, 1'b1, ST_U, 4'd6, 4'd0, 4'd0, 1'b1, 2'b00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00));
        step();
        drive(mk(1'b0, 1'b1, ST_I, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        dut.regs_r[6] = dut.regs_r[6] ^ 8'h01;
        step();
        check("par_before", {7'd0, perr}, 8'h00);
        drive(mk(1'b0, 1'b1, ST_R, 4'd0, 4'd6, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        step();
        check("par_rs", rs, 8'h3D);
        check("par_set", {7'd0, perr}, 8'h01);
        drive(mk(1'b0, 1'b1, ST_R, 4'd0, 4'd1, 4'd2, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        for (int k = 0; k < 3; k++) step();
        check("par_sticky", {7'd0, perr}, 8'h01);
        drive(mk(1'b1, 1'b1, ST_I, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        step();
        check("par_cleared", {7'd0, perr}, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thread_regfile.md
THREAD_REGFILE -- requirements
Module: thread_regfile

Interface
REQ-001 Parameter THREAD_ID, default 0: this thread's index within its block; reset value of R15.
REQ-002 Parameter THREADS_PER_BLOCK, default 4: reset value of R14 (%blockDim).
REQ-003 Parameter DATA_BITS, default 8: register, operand and writeback width.
REQ-004 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port enable, input, 1: thread active; when low, all state holds.
REQ-007 Port block_id, input, DATA_BITS: current block index, mirrored into R13.
REQ-008 Port core_state, input, 3: core phase; 3'b011 = REQUEST, 3'b110 = UPDATE; other codes are no-ops here.
REQ-009 Ports decoded_rd_address, decoded_rs_address and decoded_rt_address, input, 4 each: destination and source register indices.
REQ-010 Port decoded_reg_write_enable, input, 1: instruction writes rd.
REQ-011 Port decoded_reg_input_mux, input, 2: writeback source; 00 ALU, 01 MEMORY, 10 CONSTANT, 11 reserved.
REQ-012 Port decoded_immediate, input, DATA_BITS: CONSTANT writeback value.
REQ-013 Ports alu_out and lsu_out, input, DATA_BITS each: ALU result and load result.
REQ-014 Ports rs and rt, output, DATA_BITS each: registered operands driving the ALU and LSU.
REQ-015 Port parity_error, output, 1: sticky register-corruption flag.

Function
REQ-016 Storage SHALL be 16 registers: R0-R12 general purpose; R13 %blockIdx, R14 %blockDim and R15 %threadIdx are read-only.
REQ-017 Read, every enabled cycle with core_state == REQUEST: rs <= R[decoded_rs_address] and rt <= R[decoded_rt_address], 1-cycle latency; otherwise rs/rt hold.
REQ-018 Write, every enabled cycle with core_state == UPDATE, decoded_reg_write_enable = 1 and decoded_rd_address < 13: R[rd] <= the selected writeback source.
REQ-019 decoded_reg_input_mux = 11 SHALL suppress the write; all registers hold.
REQ-020 Writes with rd in 13-15 SHALL be silently dropped, with no error flagged.
REQ-021 R13 SHALL load block_id on every enabled, non-reset cycle, independent of core_state.
REQ-022 Reads in REQUEST SHALL return the value as of that cycle's start; no read/write bypass, since REQUEST and UPDATE never coincide.
REQ-023 enable = 0 SHALL freeze R0-R15, rs, rt and parity_error, including R13.
REQ-024 All writeback arithmetic is pass-through, truncated to DATA_BITS; no sign or zero extension.

Reset
REQ-025 On reset: R0-R12 = 0, R13 = 0, R14 = THREADS_PER_BLOCK, R15 = THREAD_ID, rs = 0, rt = 0, parity_error = 0.
REQ-026 reset SHALL override enable and core_state; a reset asserted mid-UPDATE discards the pending write.

Configuration
REQ-027 Macro REGFILE_PARITY_EN SHALL compile parity protection in or out.
REQ-028 With REGFILE_PARITY_EN: each register stores an even-parity bit, computed on every write (including R13 and reset).
REQ-029 With REGFILE_PARITY_EN: each REQUEST read rechecks both sources, and any mismatch sets parity_error one cycle later, sticky until reset.
REQ-030 Without REGFILE_PARITY_EN: no parity storage exists and parity_error is tied 0; the port list is unchanged.

Structure
REQ-031 Shared package gpu_pkg SHALL hold the core_state encodings, the reg_input_mux encodings, the read-only index constants (13, 14, 15) and the register count (16).
REQ-032 The writeback selector SHALL be a combinational sub-module, regfile_wb_select (mux, immediate, alu_out, lsu_out -> data, valid).

Verification
REQ-033 Reset with THREAD_ID=2 and THREADS_PER_BLOCK=4, then REQUEST rs=15, rt=14 -> rs=2, rt=4 one cycle later.
REQ-034 UPDATE with rd=5, mux=00, alu_out=8'h2A; then REQUEST rs=5 -> rs=8'h2A; repeat with mux=10, immediate=8'h07 -> 8'h07.
REQ-035 UPDATE with rd=15, mux=01, lsu_out=8'hFF -> a later read of R15 still returns THREAD_ID; rd=3 with mux=11 -> R3 unchanged.
REQ-036 enable=0 with block_id=9 and UPDATE rd=1 -> R1 and R13 unchanged; re-enable for one cycle -> R13 reads 9.
REQ-037 Assert reset in the same cycle as UPDATE rd=4, alu_out=8'h55 -> R4 = 0 and rs = rt = 0.
REQ-038 With REGFILE_PARITY_EN, force-flip R6 bit 0, then REQUEST rs=6 -> parity_error = 1 and stays 1 until reset.
